exec_unit: RTL and testbench
============================

Name: exec_unit

Overview:
- Execute-stage datapath core: combinational RV32I integer ALU, branch comparator and branch-decision logic.
- Followed by an execute/memory pipeline register holding the ALU result and the branch-taken flag.
- Sits between the operand-bypass mux (which supplies in_a/in_b) and the data-memory / PC-redirect logic.

Parameters:
- XLEN, 32, datapath width. Only 32 is required; shift amounts use in_b[4:0].

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- in_a  in  XLEN  ALU operand A (rs1 or PC, already bypassed).
- in_b  in  XLEN  ALU operand B (rs2, imm or shamt, already bypassed).
- alu_sel  in  4  ALU operation code.
- cmp_a  in  XLEN  branch comparator operand A (rs1 data).
- cmp_b  in  XLEN  branch comparator operand B (rs2 data).
- unsign  in  1  1 = unsigned compare (BLTU/BGEU), 0 = signed.
- brn_enable  in  1  instruction is a conditional branch.
- brn_signal  in  2  branch condition select.
- stall  in  1  1 = hold the pipeline register.
- alu_out  out  XLEN  combinational ALU result.
- br_eq  out  1  combinational cmp_a == cmp_b.
- br_lt  out  1  combinational cmp_a < cmp_b, signedness per unsign.
- br_tk  out  1  combinational branch-taken.
- alu_out_q  out  XLEN  registered alu_out.
- br_tk_q  out  1  registered br_tk.

Behaviour:
- ALU is purely combinational. alu_sel encoding is {funct7[5], funct3}:
  - 0000 ADD
  - 1000 SUB
  - 0001 SLL
  - 0010 SLT (signed)
  - 0011 SLTU
  - 0100 XOR
  - 0101 SRL
  - 1101 SRA
  - 0110 OR
  - 0111 AND
  - 1001 PASS_B (out = in_b, used for LUI)
  - 1010, 1011, 1100, 1110, 1111: out = 0.
- ALU arithmetic rules:
  - ADD/SUB wrap modulo 2^32; no flags are produced.
  - Shifts use in_b[4:0] only; upper bits of in_b are ignored.
  - SRA replicates in_a[31].
  - SLT/SLTU produce 32'h0000_0001 or 32'h0000_0000.
- Bubble convention: bubbles arrive as alu_sel = 0 with zero operands and must yield alu_out = 0.
- Comparator: br_eq = (cmp_a == cmp_b). br_lt is a signed compare when unsign = 0 and an unsigned compare when unsign = 1. Combinational.
- Branch control: br_tk = brn_enable AND condition, where the condition is selected by brn_signal:
  - 00 BEQ: br_eq
  - 01 BNE: !br_eq
  - 10 BLT/BLTU: br_lt
  - 11 BGE/BGEU: !br_lt
- When brn_enable = 0, br_tk = 0 regardless of the other inputs.
- Pipeline register:
  - Asynchronous reset (reset = 0) forces alu_out_q = 0 and br_tk_q = 0 immediately.
  - On each rising clock edge with reset = 1 and stall = 0, the register captures alu_out and br_tk (1-cycle latency).
  - With stall = 1 the register holds its value.
  - Reset asserted mid-operation overrides stall and clears both registers at once. Release of reset is synchronised externally.
- No internal state beyond the pipeline register. Combinational outputs must have no latches; every case has a default.

Decomposition:
- Shared package exec_pkg holds the ALU opcode localparams (ALU_ADD … ALU_PASSB) and the branch condition codes (BR_EQ, BR_NE, BR_LT, BR_GE).
- One natural sub-module, exec_alu (combinational ALU).
- Comparator, branch decision and pipeline register stay in exec_unit.

Test Plan:
- ADD/SUB wrap: in_a = 32'hFFFF_FFFF, in_b = 1, alu_sel = 0000 -> alu_out = 0. alu_sel = 1000, in_a = 0, in_b = 1 -> 32'hFFFF_FFFF.
- Shifts: in_a = 32'h8000_0000, in_b = 32'h0000_0024 (shamt 4):
  - SRL -> 32'h0800_0000
  - SRA -> 32'hF800_0000
  - SLL with in_a = 1 -> 32'h0000_0010
- SLT vs SLTU: in_a = 32'hFFFF_FFFF, in_b = 1 -> SLT = 1, SLTU = 0. PASS_B with in_b = 32'h1234_5000 -> 32'h1234_5000. Code 1111 -> 0.
- Branch decisions:
  - cmp_a = -1, cmp_b = 1, unsign = 0, brn_signal = 10, brn_enable = 1 -> br_lt = 1, br_tk = 1.
  - Same operands with unsign = 1 -> br_lt = 0, br_tk = 0.
  - brn_signal = 11 with unsign = 1 -> br_tk = 1.
  - brn_enable = 0 -> br_tk = 0.
- BEQ/BNE: cmp_a = cmp_b = 32'hDEAD_BEEF, enable = 1 -> brn_signal 00 gives br_tk = 1, brn_signal 01 gives br_tk = 0.
- Register:
  - Drive ADD 5+7 -> alu_out_q = 12 one edge later.
  - Assert stall and change inputs -> alu_out_q stays 12.
  - Drop reset asynchronously between edges -> alu_out_q = 0 and br_tk_q = 0 before the next edge.

Source files
------------

// File: rtl/exec_pkg.sv
// ---------------------------------------------------------------------------
// exec_pkg
//   Shared definitions for the execute stage.
//   - ALU operation codes. Each code is {funct7[5], funct3}.
//   - Branch condition selects, as carried on brn_signal.
//   - branch_cond(): turns the comparator flags into the selected condition.
// ---------------------------------------------------------------------------
package exec_pkg;

  localparam int XLEN_DEFAULT = 32;

  // ALU operation codes, {funct7[5], funct3}
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b1000;
  localparam logic [3:0] ALU_SLL   = 4'b0001;
  localparam logic [3:0] ALU_SLT   = 4'b0010;
  localparam logic [3:0] ALU_SLTU  = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_SRA   = 4'b1101;
  localparam logic [3:0] ALU_OR    = 4'b0110;
  localparam logic [3:0] ALU_AND   = 4'b0111;
  localparam logic [3:0] ALU_PASSB = 4'b1001;

  // Branch condition selects
  localparam logic [1:0] BR_EQ = 2'b00;
  localparam logic [1:0] BR_NE = 2'b01;
  localparam logic [1:0] BR_LT = 2'b10;
  localparam logic [1:0] BR_GE = 2'b11;

  // Pick the branch condition named by sel from the comparator flags.
  // The signed/unsigned choice has already been folded into lt.
  function automatic logic branch_cond(input logic [1:0] sel,
                                       input logic       eq,
                                       input logic       lt);
    logic cond;
    case (sel)
      BR_EQ:   cond = eq;
      BR_NE:   cond = !eq;
      BR_LT:   cond = lt;
      BR_GE:   cond = !lt;
      default: cond = 1'b0;
    endcase
    return cond;
  endfunction

endpackage : exec_pkg

// File: rtl/exec_if.sv
// ---------------------------------------------------------------------------
// exec_if
//   Bundles the execute-stage operand, control and result signals.
//   master : the side that supplies operands and uses the results
//            (the bypass mux upstream, and memory/PC logic downstream).
//   slave  : exec_unit.
//   Signals
//     in_a, in_b        ALU operands (already bypassed)
//     alu_sel           ALU operation code
//     cmp_a, cmp_b      branch comparator operands
//     unsign            1 = unsigned compare
//     brn_enable        instruction is a conditional branch
//     brn_signal        branch condition select
//     stall             hold the pipeline register
//     alu_out           combinational ALU result
//     br_eq, br_lt      combinational comparator flags
//     br_tk             combinational branch-taken
//     alu_out_q         registered alu_out
//     br_tk_q           registered br_tk
// ---------------------------------------------------------------------------
interface exec_if #(
  parameter int XLEN = 32
);

  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic [3:0]      alu_sel;
  logic [XLEN-1:0] cmp_a;
  logic [XLEN-1:0] cmp_b;
  logic            unsign;
  logic            brn_enable;
  logic [1:0]      brn_signal;
  logic            stall;
  logic [XLEN-1:0] alu_out;
  logic            br_eq;
  logic            br_lt;
  logic            br_tk;
  logic [XLEN-1:0] alu_out_q;
  logic            br_tk_q;

  modport master (
    output in_a, in_b, alu_sel, cmp_a, cmp_b, unsign, brn_enable, brn_signal, stall,
    input  alu_out, br_eq, br_lt, br_tk, alu_out_q, br_tk_q
  );

  modport slave (
    input  in_a, in_b, alu_sel, cmp_a, cmp_b, unsign, brn_enable, brn_signal, stall,
    output alu_out, br_eq, br_lt, br_tk, alu_out_q, br_tk_q
  );

endinterface : exec_if

// File: rtl/exec_alu.sv
// ---------------------------------------------------------------------------
// exec_alu
//   Combinational RV32I integer ALU.
//   Ports
//     i_a      operand A
//     i_b      operand B. Shifts use only i_b[4:0].
//     i_sel    operation code, {funct7[5], funct3}
//     o_result result. Unused codes give zero, and a bubble (ADD of zeros)
//              also gives zero.
// ---------------------------------------------------------------------------
module exec_alu
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [3:0]      i_sel,
  output logic [XLEN-1:0] o_result
);

  logic [4:0] w_shamt;

  assign w_shamt = i_b[4:0];

  always_comb begin
    // NOTE: combinational blocks use blocking '='. Assigning a default before
    // the case means every path drives o_result, so no latch is inferred.
    o_result = '0;
    case (i_sel)
      ALU_ADD:   o_result = i_a + i_b;
      ALU_SUB:   o_result = i_a - i_b;
      ALU_SLL:   o_result = i_a << w_shamt;
      ALU_SLT:   o_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      ALU_SLTU:  o_result = {{(XLEN-1){1'b0}}, (i_a < i_b)};
      ALU_XOR:   o_result = i_a ^ i_b;
      ALU_SRL:   o_result = i_a >> w_shamt;
      // The arithmetic shift fills the vacated bits with a copy of i_a[XLEN-1].
      ALU_SRA:   o_result = $unsigned($signed(i_a) >>> w_shamt);
      ALU_OR:    o_result = i_a | i_b;
      ALU_AND:   o_result = i_a & i_b;
      ALU_PASSB: o_result = i_b;
      default:   o_result = '0;
    endcase
  end

endmodule : exec_alu

// File: rtl/exec_unit.sv
// ---------------------------------------------------------------------------
// exec_unit
//   Execute stage: ALU, branch comparator and branch decision, followed by
//   the execute/memory pipeline register.
//   Ports
//     clock  rising-edge clock
//     reset  asynchronous, active-low. Clears the pipeline register at once,
//            even while stalled.
//     bus    exec_if.slave. Carries the operands, the controls, the
//            combinational results and the registered results.
// ---------------------------------------------------------------------------
module exec_unit
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic clock,
  input  logic reset,
  exec_if.slave bus
);

  logic [XLEN-1:0] w_alu_out;
  logic            w_br_eq;
  logic            w_br_lt;
  logic            w_br_tk;
  logic [XLEN-1:0] r_alu_out_q;
  logic            r_br_tk_q;

  exec_alu #(
    .XLEN (XLEN)
  ) u_alu (
    .i_a      (bus.in_a),
    .i_b      (bus.in_b),
    .i_sel    (bus.alu_sel),
    .o_result (w_alu_out)
  );

  // Comparator. The unsign input selects a signed or an unsigned less-than.
  assign w_br_eq = (bus.cmp_a == bus.cmp_b);
  assign w_br_lt = bus.unsign ? (bus.cmp_a < bus.cmp_b)
                              : ($signed(bus.cmp_a) < $signed(bus.cmp_b));

  // Branch decision. A non-branch instruction is never taken.
  assign w_br_tk = bus.brn_enable & branch_cond(bus.brn_signal, w_br_eq, w_br_lt);

  // Execute/memory pipeline register. Reset takes priority over stall.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking '<=', so every flop samples
    // its pre-edge inputs regardless of statement order.
    if (!reset) begin
      r_alu_out_q <= '0;
      r_br_tk_q   <= 1'b0;
    end else if (!bus.stall) begin
      r_alu_out_q <= w_alu_out;
      r_br_tk_q   <= w_br_tk;
    end
  end

  assign bus.alu_out   = w_alu_out;
  assign bus.br_eq     = w_br_eq;
  assign bus.br_lt     = w_br_lt;
  assign bus.br_tk     = w_br_tk;
  assign bus.alu_out_q = r_alu_out_q;
  assign bus.br_tk_q   = r_br_tk_q;

endmodule : exec_unit

// File: tb/tb_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_exec_unit
//   Directed self-checking bench for exec_unit. Every expected value is
//   written out by hand below.
// ---------------------------------------------------------------------------
module tb_exec_unit;
  import exec_pkg::*;

  logic clock;
  logic reset;
  int   n_total;
  int   n_bad;

  exec_if #(.XLEN(32)) bus ();

  exec_unit #(.XLEN(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic alu_vec(input string tag, input logic [3:0] sel,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
    bus.alu_sel = sel;
    bus.in_a    = a;
    bus.in_b    = b;
    #1;
    check(tag, bus.alu_out, exp);
  endtask

  task automatic br_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic uns, input logic en, input logic [1:0] sig,
                        input logic exp_lt, input logic exp_tk);
    bus.cmp_a      = a;
    bus.cmp_b      = b;
    bus.unsign     = uns;
    bus.brn_enable = en;
    bus.brn_signal = sig;
    #1;
    check({tag, "_lt"}, {31'd0, bus.br_lt}, {31'd0, exp_lt});
    check({tag, "_tk"}, {31'd0, bus.br_tk}, {31'd0, exp_tk});
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    reset   = 1'b0;
    bus.in_a       = '0;
    bus.in_b       = '0;
    bus.alu_sel    = ALU_ADD;
    bus.cmp_a      = '0;
    bus.cmp_b      = '0;
    bus.unsign     = 1'b0;
    bus.brn_enable = 1'b0;
    bus.brn_signal = BR_EQ;
    bus.stall      = 1'b0;

    // Reset state, and the bubble convention
    #2;
    check("rst_alu_q", bus.alu_out_q, 32'h0);
    check("rst_tk_q",  {31'd0, bus.br_tk_q}, 32'h0);
    check("bubble",    bus.alu_out, 32'h0);

    // ALU vectors
    alu_vec("add_wrap",  ALU_ADD,   32'hFFFF_FFFF, 32'h1,          32'h0);
    alu_vec("sub_wrap",  ALU_SUB,   32'h0,         32'h1,          32'hFFFF_FFFF);
    alu_vec("srl",       ALU_SRL,   32'h8000_0000, 32'h0000_0024,  32'h0800_0000);
    alu_vec("sra_neg",   ALU_SRA,   32'h8000_0000, 32'h0000_0024,  32'hF800_0000);
    alu_vec("sra_pos",   ALU_SRA,   32'h4000_0000, 32'hFFFF_FFE1,  32'h2000_0000);
    alu_vec("sll",       ALU_SLL,   32'h1,         32'h0000_0024,  32'h0000_0010);
    alu_vec("slt_neg",   ALU_SLT,   32'hFFFF_FFFF, 32'h1,          32'h1);
    alu_vec("sltu_big",  ALU_SLTU,  32'hFFFF_FFFF, 32'h1,          32'h0);
    alu_vec("slt_pos",   ALU_SLT,   32'h1,         32'hFFFF_FFFF,  32'h0);
    alu_vec("sltu_sm",   ALU_SLTU,  32'h1,         32'hFFFF_FFFF,  32'h1);
    alu_vec("xor",       ALU_XOR,   32'hF0F0_F0F0, 32'h0FF0_0FF0,  32'hFF00_FF00);
    alu_vec("or",        ALU_OR,    32'hF000_000F, 32'h0000_F0F0,  32'hF000_F0FF);
    alu_vec("and",       ALU_AND,   32'hF0F0_F0F0, 32'hFF00_FF00,  32'hF000_F000);
    alu_vec("passb",     ALU_PASSB, 32'hAAAA_AAAA, 32'h1234_5000,  32'h1234_5000);
    alu_vec("code_1111", 4'b1111,   32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'h0);
    alu_vec("code_1010", 4'b1010,   32'h1234_5678, 32'h1,          32'h0);

    // Branch vectors
    br_vec("blt",      32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, BR_LT, 1'b1, 1'b1);
    br_vec("bltu",     32'hFFFF_FFFF, 32'h1, 1'b1, 1'b1, BR_LT, 1'b0, 1'b0);
    br_vec("bgeu",     32'hFFFF_FFFF, 32'h1, 1'b1, 1'b1, BR_GE, 1'b0, 1'b1);
    br_vec("bge",      32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, BR_GE, 1'b1, 1'b0);
    br_vec("blt_off",  32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, BR_LT, 1'b1, 1'b0);
    br_vec("beq",      32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b1, BR_EQ, 1'b0, 1'b1);
    check("beq_eq", {31'd0, bus.br_eq}, 32'h1);
    br_vec("bne",      32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b1, BR_NE, 1'b0, 1'b0);
    br_vec("bne_diff", 32'hDEAD_BEEF, 32'hDEAD_BEEE, 1'b0, 1'b1, BR_NE, 1'b0, 1'b1);
    check("bne_eq", {31'd0, bus.br_eq}, 32'h0);

    // Pipeline register: release reset away from the edge
    @(negedge clock);
    reset = 1'b1;
    bus.alu_sel    = ALU_ADD;
    bus.in_a       = 32'd5;
    bus.in_b       = 32'd7;
    bus.cmp_a      = 32'h55;
    bus.cmp_b      = 32'h55;
    bus.brn_enable = 1'b1;
    bus.brn_signal = BR_EQ;
    bus.stall      = 1'b0;
    #1;
    check("pre_edge_q", bus.alu_out_q, 32'h0);
    @(posedge clock);
    #1;
    check("cap_alu_q", bus.alu_out_q, 32'd12);
    check("cap_tk_q",  {31'd0, bus.br_tk_q}, 32'h1);

    // Stall holds the register while the inputs change
    @(negedge clock);
    bus.stall      = 1'b1;
    bus.in_a       = 32'd100;
    bus.in_b       = 32'd200;
    bus.brn_signal = BR_NE;
    @(posedge clock);
    #1;
    check("stall_alu_q", bus.alu_out_q, 32'd12);
    check("stall_tk_q",  {31'd0, bus.br_tk_q}, 32'h1);
    @(posedge clock);
    #1;
    check("stall2_alu_q", bus.alu_out_q, 32'd12);

    // Releasing stall captures the new inputs
    @(negedge clock);
    bus.stall = 1'b0;
    @(posedge clock);
    #1;
    check("unstall_alu_q", bus.alu_out_q, 32'd300);
    check("unstall_tk_q",  {31'd0, bus.br_tk_q}, 32'h0);

    // Load a taken branch, then assert reset between edges while stalled
    @(negedge clock);
    bus.brn_signal = BR_EQ;
    @(posedge clock);
    #1;
    check("reload_tk_q", {31'd0, bus.br_tk_q}, 32'h1);
    #2;
    bus.stall = 1'b1;
    reset     = 1'b0;
    #1;
    check("async_alu_q", bus.alu_out_q, 32'h0);
    check("async_tk_q",  {31'd0, bus.br_tk_q}, 32'h0);

    // Release reset at a falling edge, then the next capture works again
    @(negedge clock);
    reset     = 1'b1;
    bus.stall = 1'b0;
    @(posedge clock);
    #1;
    check("post_rst_alu_q", bus.alu_out_q, 32'd300);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_exec_unit
